// File: rtl/dbus_dmem_banked_pkg.sv
// Shared constants for the banked data memory: default geometry and arbitration mode codes.
package dbus_dmem_banked_pkg;
  localparam int ARB_RR      = 0;
  localparam int ARB_FIXED   = 1;
  localparam int DMEM_NBANKS = 4;
  localparam int DMEM_ADDRW  = 12;

  // Index width that stays at least one bit wide for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dbus_dmem_banked_arb.sv
// Per-bank arbiter: picks one requesting core per cycle, round-robin or fixed priority.
module dbus_dmem_banked_arb
  import dbus_dmem_banked_pkg::*;
#(
  parameter int NCORES   = 4,
  parameter int ARB_MODE = ARB_RR,
  localparam int CW      = idx_w(NCORES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCORES-1:0] req,
  output logic [NCORES-1:0] grant,
  output logic [CW-1:0]     grant_idx,
  output logic              grant_vld
);
  logic [CW-1:0] ptr;
  logic [CW-1:0] cand;

  // Search order starts just after the last grantee; fixed mode scans from core 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (ARB_MODE == ARB_FIXED) cand = CW'(i);
      else                       cand = CW'((int'(ptr) + 1 + i) % NCORES);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ptr <= CW'(NCORES - 1);
    else if (grant_vld) ptr <= grant_idx;
  end
endmodule

// File: rtl/dbus_dmem_banked.sv
// Word-interleaved multi-bank shared data memory with per-bank arbitration and LR/SC reservations.
module dbus_dmem_banked
  import dbus_dmem_banked_pkg::*;
#(
  parameter int NCORES   = 4,
  parameter int NBANKS   = DMEM_NBANKS,
  parameter int ADDRW    = DMEM_ADDRW,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCORES-1:0]    re_packed_i,
  input  logic [NCORES-1:0]    we_packed_i,
  input  logic [ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0] wdata_packed_i,
  input  logic [4*NCORES-1:0]  wstrb_packed_i,
  input  logic [NCORES-1:0]    is_lr_packed_i,
  input  logic [NCORES-1:0]    is_sc_packed_i,
  output logic [32*NCORES-1:0] rdata_packed_o,
  output logic [NCORES-1:0]    stall_packed_o
);
  localparam int BBITS = (NBANKS > 1) ? $clog2(NBANKS) : 0;
  localparam int BW    = idx_w(NBANKS);
  localparam int CW    = idx_w(NCORES);
  localparam int LW    = ADDRW - BBITS;

  logic [ADDRW-1:0]  addr      [NCORES];
  logic [31:0]       wdata     [NCORES];
  logic [3:0]        wstrb     [NCORES];
  logic [BW-1:0]     bank      [NCORES];
  logic [LW-1:0]     word      [NCORES];
  logic [NCORES-1:0] req, grant, sc_ok;
  logic [NCORES-1:0] bgrant    [NBANKS];
  logic [CW-1:0]     bidx      [NBANKS];
  logic [NBANKS-1:0] bvld, bwen;
  logic [ADDRW-1:0]  bwaddr    [NBANKS];
  logic [31:0]       bq        [NBANKS];
  logic [NCORES-1:0] resv_v;
  logic [ADDRW-1:0]  resv_a    [NCORES];
  logic [NCORES-1:0] pend_v, pend_sc, pend_fail;
  logic [BW-1:0]     pend_bank [NCORES];
  logic [31:0]       hold      [NCORES];
  logic [31:0]       rdata     [NCORES];

  // Reset masks requests so nothing is granted or stalled while it is held.
  assign req            = rst_i ? '0 : (re_packed_i | we_packed_i);
  assign stall_packed_o = req & ~grant;

  always_comb begin
    grant = '0;
    for (int b = 0; b < NBANKS; b++) grant = grant | bgrant[b];
  end

  for (genvar c = 0; c < NCORES; c++) begin : g_core
    assign addr[c]  = addr_packed_i[c*ADDRW +: ADDRW];
    assign wdata[c] = wdata_packed_i[c*32 +: 32];
    assign wstrb[c] = wstrb_packed_i[c*4 +: 4];
    if (BBITS == 0) begin : g_one
      assign bank[c] = '0;
      assign word[c] = addr[c];
    end else begin : g_many
      assign bank[c] = addr[c][BBITS-1:0];
      assign word[c] = addr[c][ADDRW-1:BBITS];
    end
    assign sc_ok[c] = resv_v[c] && (resv_a[c] == addr[c]);
    assign rdata[c] = !pend_v[c] ? hold[c] :
                      pend_sc[c] ? {31'b0, pend_fail[c]} : bq[pend_bank[c]];
    assign rdata_packed_o[c*32 +: 32] = rdata[c];
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [NCORES-1:0] breq;
    logic [CW-1:0]     sel;
    logic              wen, ren;
    logic [31:0]       q;
    logic [31:0]       mem [2**LW];

    for (genvar c = 0; c < NCORES; c++) begin : g_req
      assign breq[c] = req[c] && (bank[c] == BW'(b));
    end

    dbus_dmem_banked_arb #(.NCORES(NCORES), .ARB_MODE(ARB_MODE)) u_arb (
      .clk       (clk_i),
      .rst       (rst_i),
      .req       (breq),
      .grant     (bgrant[b]),
      .grant_idx (bidx[b]),
      .grant_vld (bvld[b])
    );

    // A failed SC still occupies the bank but must not touch memory.
    assign sel       = bidx[b];
    assign wen       = bvld[b] && we_packed_i[sel] && (!is_sc_packed_i[sel] || sc_ok[sel]);
    assign ren       = bvld[b] && !we_packed_i[sel];
    assign bwen[b]   = wen;
    assign bwaddr[b] = addr[sel];
    assign bq[b]     = q;

    always_ff @(posedge clk_i) begin
      if (wen)
        for (int j = 0; j < 4; j++)
          if (wstrb[sel][j]) mem[word[sel]][8*j +: 8] <= wdata[sel][8*j +: 8];
      if (ren) q <= mem[word[sel]];
    end
  end

  // Reservation valid bits: own LR sets, own SC clears, other cores' writes to the word clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resv_v <= '0;
    end else begin
      for (int k = 0; k < NCORES; k++) begin
        for (int b = 0; b < NBANKS; b++)
          if (bwen[b] && (bidx[b] != CW'(k)) && (bwaddr[b] == resv_a[k])) resv_v[k] <= 1'b0;
        if (grant[k] && we_packed_i[k] && is_sc_packed_i[k])
          resv_v[k] <= 1'b0;
        else if (grant[k] && !we_packed_i[k] && is_lr_packed_i[k])
          resv_v[k] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NCORES; k++) begin
      if (grant[k] && !we_packed_i[k] && is_lr_packed_i[k]) resv_a[k] <= addr[k];
      if (grant[k]) pend_bank[k] <= bank[k];
    end
  end

  // Response tracking: a pending read/SC result is shown for one cycle, then latched into hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_v    <= '0;
      pend_sc   <= '0;
      pend_fail <= '0;
      for (int k = 0; k < NCORES; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < NCORES; k++) begin
        pend_v[k]    <= grant[k] && (!we_packed_i[k] || is_sc_packed_i[k]);
        pend_sc[k]   <= we_packed_i[k] && is_sc_packed_i[k];
        pend_fail[k] <= !sc_ok[k];
        if (pend_v[k]) hold[k] <= rdata[k];
      end
    end
  end
endmodule

// File: tb/tb_dbus_dmem_banked.sv
// Randomized and directed bench for dbus_dmem_banked against a behavioural memory model.
module tb_dbus_dmem_banked;
  import dbus_dmem_banked_pkg::*;
  localparam int NC = 4;
  localparam int NB = 4;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0]    re, we, lr, sc;
  logic [AW*NC-1:0] addr;
  logic [32*NC-1:0] wdata;
  logic [4*NC-1:0]  wstrb;
  logic [32*NC-1:0] rdata;
  logic [NC-1:0]    stall;

  logic [NC-1:0]    fx_re, fx_zero;
  logic [AW*NC-1:0] fx_addr;
  logic [32*NC-1:0] fx_wdata, fx_rdata;
  logic [4*NC-1:0]  fx_wstrb;
  logic [NC-1:0]    fx_stall;

  dbus_dmem_banked #(.NCORES(NC), .NBANKS(NB), .ADDRW(AW), .ARB_MODE(ARB_RR)) dut (
    .clk_i(clk), .rst_i(rst), .re_packed_i(re), .we_packed_i(we), .addr_packed_i(addr),
    .wdata_packed_i(wdata), .wstrb_packed_i(wstrb), .is_lr_packed_i(lr), .is_sc_packed_i(sc),
    .rdata_packed_o(rdata), .stall_packed_o(stall));

  dbus_dmem_banked #(.NCORES(NC), .NBANKS(NB), .ADDRW(AW), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk_i(clk), .rst_i(rst), .re_packed_i(fx_re), .we_packed_i(fx_zero), .addr_packed_i(fx_addr),
    .wdata_packed_i(fx_wdata), .wstrb_packed_i(fx_wstrb), .is_lr_packed_i(fx_zero),
    .is_sc_packed_i(fx_zero), .rdata_packed_o(fx_rdata), .stall_packed_o(fx_stall));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [31:0] mem_m [1<<AW];
  bit          rv_m   [NC];
  int          ra_m   [NC];
  int          last_m [NB];
  logic [31:0] exp_rd [NC];
  bit          stall_m[NC];

  function automatic int a_of(input int c);
    return int'(addr[c*AW +: AW]);
  endfunction

  function automatic logic [31:0] fv(input int a);
    return 32'hABC00000 | a;
  endfunction

  always @(negedge clk) begin
    int win [NB];
    int cd, a, b;
    bit ok;
    bit wr_do [NC];
    logic [31:0] d;
    logic [3:0]  s;
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        chk("reset_stall", {31'b0, stall[c]}, 32'h0);
        chk("reset_rdata", rdata[c*32 +: 32], 32'h0);
        exp_rd[c] = 32'h0; rv_m[c] = 0; stall_m[c] = 0;
      end
      for (int k = 0; k < NB; k++) last_m[k] = NC - 1;
    end else begin
      // Winner per bank: first requester in rotation order after the bank's last winner.
      for (int k = 0; k < NB; k++) begin
        win[k] = -1;
        for (int i = 1; i <= NC; i++) begin
          cd = (last_m[k] + i) % NC;
          if (win[k] < 0 && (re[cd] || we[cd]) && (a_of(cd) % NB) == k) win[k] = cd;
        end
      end
      for (int c = 0; c < NC; c++) begin
        stall_m[c] = (re[c] || we[c]) && win[a_of(c) % NB] != c;
        chk("stall", {31'b0, stall[c]}, {31'b0, stall_m[c]});
        chk("rdata", rdata[c*32 +: 32], exp_rd[c]);
      end
      for (int c = 0; c < NC; c++) begin
        wr_do[c] = 0;
        a = a_of(c);
        if (win[a % NB] == c) begin
          if (we[c]) begin
            if (sc[c]) begin
              ok = rv_m[c] && ra_m[c] == a;
              exp_rd[c] = ok ? 32'd0 : 32'd1;
              rv_m[c] = 0;
              wr_do[c] = ok;
            end else wr_do[c] = 1;
          end else begin
            exp_rd[c] = mem_m[a];
            if (lr[c]) begin rv_m[c] = 1; ra_m[c] = a; end
          end
        end
      end
      for (int k = 0; k < NB; k++) if (win[k] >= 0) last_m[k] = win[k];
      for (int c = 0; c < NC; c++) if (wr_do[c]) begin
        a = a_of(c);
        d = wdata[c*32 +: 32];
        s = wstrb[c*4 +: 4];
        for (int j = 0; j < 4; j++) if (s[j]) mem_m[a][8*j +: 8] = d[8*j +: 8];
        for (int k = 0; k < NC; k++) if (k != c && rv_m[k] && ra_m[k] == a) rv_m[k] = 0;
      end
      b = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input bit r, input bit w, input int a,
                         input logic [31:0] d, input logic [3:0] s, input bit l, input bit scb);
    re[c] = r; we[c] = w; lr[c] = l; sc[c] = scb;
    addr[c*AW +: AW] = AW'(a);
    wdata[c*32 +: 32] = d;
    wstrb[c*4 +: 4] = s;
  endtask

  task automatic idle(input int c);
    set_req(c, 0, 0, 0, 32'h0, 4'h0, 0, 0);
  endtask

  task automatic rnd_req(input int c);
    int r;
    int a;
    r = $urandom_range(0, 9);
    a = $urandom_range(0, 31);
    case (r)
      3, 4:    set_req(c, 1, 0, a, 32'h0, 4'h0, 0, 0);
      5:       set_req(c, 1, 0, a, 32'h0, 4'h0, 1, 0);
      6, 7:    set_req(c, 0, 1, a, $urandom, 4'($urandom_range(0, 15)), 0, 0);
      8:       set_req(c, 0, 1, a, $urandom, 4'($urandom_range(0, 15)), 0, 1);
      9:       set_req(c, 1, 1, a, $urandom, 4'hF, 0, 0);
      default: idle(c);
    endcase
  endtask

  initial begin
    re = '0; we = '0; lr = '0; sc = '0; addr = '0; wdata = '0; wstrb = '0;
    fx_re = '0; fx_zero = '0; fx_addr = '0; fx_wdata = '0; fx_wstrb = '0;
    repeat (3) cyc();
    rst = 1'b0;

    // Fill every word; each core writes its own bank so nothing contends.
    for (int i = 0; i < (1 << AW) / NC; i++) begin
      for (int c = 0; c < NC; c++) set_req(c, 0, 1, NC*i + c, fv(NC*i + c), 4'hF, 0, 0);
      cyc();
    end
    for (int c = 0; c < NC; c++) idle(c);
    cyc();

    // Four cores on four banks in parallel
    for (int c = 0; c < NC; c++) set_req(c, 1, 0, c, 32'h0, 4'h0, 0, 0);
    #2 chk("parallel_stall", {28'b0, stall}, 32'h0);
    cyc();
    for (int c = 0; c < NC; c++) idle(c);
    for (int c = 0; c < NC; c++) chk("parallel_rdata", rdata[c*32 +: 32], fv(c));

    // Round-robin on bank 0 after core 3 was the last grantee
    set_req(3, 1, 0, 4, 32'h0, 4'h0, 0, 0);
    cyc();
    idle(3);
    for (int c = 0; c < NC; c++) set_req(c, 1, 0, 4, 32'h0, 4'h0, 0, 0);
    #2 chk("rr_stall0", {28'b0, stall}, 32'hE);
    cyc(); idle(0);
    #2 chk("rr_stall1", {28'b0, stall}, 32'hC);
    cyc(); idle(1);
    #2 chk("rr_stall2", {28'b0, stall}, 32'h8);
    cyc(); idle(2);
    #2 chk("rr_stall3", {28'b0, stall}, 32'h0);
    cyc(); idle(3);
    chk("rr_rdata3", rdata[3*32 +: 32], fv(4));
    chk("rr_rdata0", rdata[0 +: 32], fv(4));

    // Fixed priority: core 0 keeps winning while it requests
    fx_re = 4'b0111;
    fx_addr = {12'd0, 12'd4, 12'd4, 12'd4};
    for (int i = 0; i < 3; i++) begin
      #2 chk("fixed_stall", {28'b0, fx_stall}, 32'h6);
      cyc();
    end
    fx_re = 4'b0110;
    #2 chk("fixed_next", {28'b0, fx_stall}, 32'h4);
    cyc();
    fx_re = '0;

    // Byte-masked write then read-back
    set_req(1, 0, 1, 8, 32'h11223344, 4'hF, 0, 0); cyc();
    set_req(1, 0, 1, 8, 32'hDEADBEEF, 4'h3, 0, 0); cyc();
    set_req(1, 1, 0, 8, 32'h0, 4'h0, 0, 0); cyc();
    idle(1);
    chk("strobe_merge", rdata[1*32 +: 32], 32'h1122BEEF);

    // LR/SC success, then SC without reservation
    set_req(0, 1, 0, 12, 32'h0, 4'h0, 1, 0); cyc();
    set_req(0, 0, 1, 12, 32'h5, 4'hF, 0, 1); cyc();
    chk("sc_ok", rdata[0 +: 32], 32'h0);
    set_req(0, 1, 0, 12, 32'h0, 4'h0, 0, 0); cyc();
    chk("sc_ok_mem", rdata[0 +: 32], 32'h5);
    set_req(0, 0, 1, 12, 32'h77, 4'hF, 0, 1); cyc();
    chk("sc_noresv", rdata[0 +: 32], 32'h1);
    set_req(0, 1, 0, 12, 32'h0, 4'h0, 0, 0); cyc();
    chk("sc_noresv_mem", rdata[0 +: 32], 32'h5);

    // Another core's write to the reserved word kills the reservation; a neighbour word does not
    set_req(0, 1, 0, 12, 32'h0, 4'h0, 1, 0); cyc(); idle(0);
    set_req(2, 0, 1, 12, 32'h22222222, 4'hF, 0, 0); cyc(); idle(2);
    set_req(0, 0, 1, 12, 32'h9, 4'hF, 0, 1); cyc();
    chk("sc_killed", rdata[0 +: 32], 32'h1);
    set_req(0, 1, 0, 12, 32'h0, 4'h0, 0, 0); cyc();
    chk("sc_killed_mem", rdata[0 +: 32], 32'h22222222);
    set_req(0, 1, 0, 12, 32'h0, 4'h0, 1, 0); cyc(); idle(0);
    set_req(2, 0, 1, 13, 32'h33, 4'hF, 0, 0); cyc(); idle(2);
    set_req(0, 0, 1, 12, 32'hA, 4'hF, 0, 1); cyc();
    chk("sc_other_word", rdata[0 +: 32], 32'h0);
    set_req(0, 1, 0, 12, 32'h0, 4'h0, 0, 0); cyc();
    chk("sc_other_mem", rdata[0 +: 32], 32'hA);

    // Reset while cores are stalled on bank 0
    set_req(0, 1, 0, 12, 32'h0, 4'h0, 1, 0); cyc();
    for (int c = 0; c < NC; c++) set_req(c, 1, 0, 4, 32'h0, 4'h0, 0, 0);
    cyc();
    for (int c = 0; c < NC; c++) if (!stall_m[c]) idle(c);
    rst = 1'b1;
    #2 chk("rst_stall_now", {28'b0, stall}, 32'h0);
    for (int c = 0; c < NC; c++) chk("rst_rdata_now", rdata[c*32 +: 32], 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    for (int c = 0; c < NC; c++) set_req(c, 1, 0, 4, 32'h0, 4'h0, 0, 0);
    #2 chk("post_rst_order", {28'b0, stall}, 32'hE);
    for (int i = 0; i < 6; i++) begin
      cyc();
      for (int c = 0; c < NC; c++) if (!stall_m[c]) idle(c);
    end
    set_req(0, 0, 1, 12, 32'hBAD, 4'hF, 0, 1); cyc(); idle(0);
    chk("post_rst_resv", rdata[0 +: 32], 32'h1);

    // Random traffic on a small address window; stalled cores hold their request
    for (int n = 0; n < 3000; n++) begin
      cyc();
      for (int c = 0; c < NC; c++) if (!stall_m[c]) rnd_req(c);
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      for (int c = 0; c < NC; c++) if (!stall_m[c]) idle(c);
    end
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
